// File: rtl/timing_sequencer.sv
// Instruction timing sequencer: a two-state IDLE/RUN controller stepping a
// sequence counter through T0..T(NUM_T-1) with a one-hot timing bus decode.
module timing_sequencer #(
    parameter int CW    = 4,
    parameter int NUM_T = 8,
    localparam int OUT_W = 2 ** CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             clr,
    input  logic             stall,
    output logic [CW-1:0]    sc,
    output logic [OUT_W-1:0] t,
    output logic             running,
    output logic             wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] SC_LAST = CW'(NUM_T - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] sc_q, sc_d;
    logic          wrap_q, wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sc_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            wrap_q  <= wrap_d;
        end
    end

    // In RUN the controls are prioritised halt > clr > stall > increment.
    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sc_d = '0;
                if (start && !halt) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = IDLE;
                    sc_d    = '0;
                end else if (clr) begin
                    sc_d = '0;
                end else if (stall) begin
                    sc_d = sc_q;
                end else if (sc_q == SC_LAST) begin
                    sc_d   = '0;
                    wrap_d = 1'b1;
                end else begin
                    sc_d = sc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sc_d    = '0;
            end
        endcase
    end

    // Decode straight from the registers so Tn appears in the same cycle as sc=n.
    always_comb begin
        t = '0;
        if (state_q == RUN) begin
            t[sc_q] = 1'b1;
        end
    end

    assign sc      = sc_q;
    assign running = (state_q == RUN);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: three parameterisations driven in lockstep and
// compared every cycle against a position-counting reference model.
module tb_timing_sequencer;

    logic clk = 1'b0;
    logic rst_n, start, halt, clr, stall;

    logic [3:0]  sc0, sc2;
    logic [2:0]  sc1;
    logic [15:0] t0, t2;
    logic [7:0]  t1;
    logic        run0, run1, run2, wrap0, wrap1, wrap2;

    int errors = 0;
    int checks = 0;

    // Reference model state per instance: running flag, T position, wrap pulse.
    int m_num[3] = '{8, 8, 5};
    bit m_run[3];
    int m_pos[3];
    bit m_wrap[3];

    always #5 clk = ~clk;

    timing_sequencer #(.CW(4), .NUM_T(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clr(clr),
        .stall(stall), .sc(sc0), .t(t0), .running(run0), .wrap(wrap0)
    );
    timing_sequencer #(.CW(3), .NUM_T(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clr(clr),
        .stall(stall), .sc(sc1), .t(t1), .running(run1), .wrap(wrap1)
    );
    timing_sequencer #(.CW(4), .NUM_T(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clr(clr),
        .stall(stall), .sc(sc2), .t(t2), .running(run2), .wrap(wrap2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_run[k]  = 1'b0;
            m_pos[k]  = 0;
            m_wrap[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            m_wrap[k] = 1'b0;
            if (!m_run[k]) begin
                m_pos[k] = 0;
                if (start && !halt) m_run[k] = 1'b1;
            end else if (halt) begin
                m_run[k] = 1'b0;
                m_pos[k] = 0;
            end else if (clr) begin
                m_pos[k] = 0;
            end else if (!stall) begin
                m_wrap[k] = (m_pos[k] == m_num[k] - 1);
                m_pos[k]  = (m_pos[k] + 1) % m_num[k];
            end
        end
    endtask

    task automatic check_inst(input int k, input string nm, input logic [31:0] sc_v,
                              input logic [31:0] t_v, input logic run_v, input logic wrap_v);
        logic [31:0] exp_t;
        exp_t = m_run[k] ? (32'd1 << m_pos[k]) : 32'd0;
        check({nm, ".sc"}, sc_v, 32'(m_pos[k]));
        check({nm, ".t"}, t_v, exp_t);
        check({nm, ".running"}, {31'd0, run_v}, {31'd0, m_run[k]});
        check({nm, ".wrap"}, {31'd0, wrap_v}, {31'd0, m_wrap[k]});
    endtask

    task automatic check_all();
        check_inst(0, "cw4_n8", 32'(sc0), 32'(t0), run0, wrap0);
        check_inst(1, "cw3_n8", 32'(sc1), 32'(t1), run1, wrap1);
        check_inst(2, "cw4_n5", 32'(sc2), 32'(t2), run2, wrap2);
    endtask

    // One clock: model follows the edge, outputs are checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asserts reset between edges, checks it took effect at once, releases on negedge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        clr   = 1'b0;
        stall = 1'b0;
        model_reset();
        #1;
        check_all();

        // Start held through reset release is taken at the first edge.
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();

        // Stall on T3 for three cycles.
        step();
        step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        step();

        // clr with stall at T5.
        step();
        clr   = 1'b1;
        stall = 1'b1;
        step();
        clr   = 1'b0;
        stall = 1'b0;

        // halt, clr and start together at T2, then start with halt in IDLE.
        step();
        step();
        halt  = 1'b1;
        clr   = 1'b1;
        start = 1'b1;
        step();
        clr = 1'b0;
        step();
        halt = 1'b0;
        step();
        start = 1'b0;

        // Reset mid-sequence at T6, then a cycle showing a new start is required.
        repeat (6) step();
        async_reset();
        step();

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            halt  = ($urandom_range(0, 24) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
